// File: rtl/sram_wr_arbiter.sv
// sram_wr_arbiter: packet-level write arbiter for the shared SRAM write path.
// Picks the highest-priority requesting port (round-robin among equal
// priorities), holds the grant for the whole packet and flags packets whose
// eop disagrees with the declared length.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   req          per-port packet-queued level
//   pri_in       packed per-port priority (larger = higher)
//   len_in       packed per-port length in words (0 = 2^LEN_WIDTH)
//   eop          per-port end-of-packet strobe
//   sram_ready   write path accepts a word this cycle
//   grant        one-hot grant, grant_idx its binary index
//   transfering  a word of the granted packet moves this cycle
//   beat_cnt     words already transferred in the current packet
//   pkt_done     one-cycle pulse after packet end
//   len_err      pulse with pkt_done when eop and length disagree
module sram_wr_arbiter #(
    parameter int NUM_PORTS      = 16,
    parameter int PORT_IDX_WIDTH = 4,
    parameter int PRI_WIDTH      = 3,
    parameter int LEN_WIDTH      = 7
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS-1:0]           req,
    input  logic [NUM_PORTS*PRI_WIDTH-1:0] pri_in,
    input  logic [NUM_PORTS*LEN_WIDTH-1:0] len_in,
    input  logic [NUM_PORTS-1:0]           eop,
    input  logic                           sram_ready,
    output logic [NUM_PORTS-1:0]           grant,
    output logic [PORT_IDX_WIDTH-1:0]      grant_idx,
    output logic                           transfering,
    output logic [LEN_WIDTH-1:0]           beat_cnt,
    output logic                           pkt_done,
    output logic                           len_err
);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        GAP
    } state_t;

    localparam logic [PORT_IDX_WIDTH:0] NP =
        (PORT_IDX_WIDTH+1)'(NUM_PORTS);
    localparam logic [PORT_IDX_WIDTH-1:0] LAST =
        PORT_IDX_WIDTH'(NUM_PORTS - 1);
    // Length field of zero encodes the maximum packet of 2^LEN_WIDTH words.
    localparam logic [LEN_WIDTH:0] FULL_LEN = {1'b1, {LEN_WIDTH{1'b0}}};

    state_t state, state_nxt;

    logic [PORT_IDX_WIDTH-1:0] rr_ptr;
    logic [LEN_WIDTH:0]        len_lat;

    logic [PRI_WIDTH-1:0] pri_a [NUM_PORTS];
    logic [LEN_WIDTH-1:0] len_a [NUM_PORTS];

    logic [PRI_WIDTH-1:0]      max_pri;
    logic                      win_found;
    logic [PORT_IDX_WIDTH-1:0] win_idx;
    logic [PORT_IDX_WIDTH:0]   scan;

    logic               start;
    logic               eop_g;
    logic               last_len;
    logic               pkt_end;
    logic [LEN_WIDTH:0] beat_ext;

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            pri_a[i] = pri_in[i*PRI_WIDTH +: PRI_WIDTH];
            len_a[i] = len_in[i*LEN_WIDTH +: LEN_WIDTH];
        end
    end

    // First pass finds the top priority among requesters; second pass
    // scans from rr_ptr upward with wrap and takes the first port at it.
    always_comb begin
        max_pri   = '0;
        win_found = 1'b0;
        win_idx   = '0;
        scan      = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (req[i] && (pri_a[i] > max_pri)) begin
                max_pri = pri_a[i];
            end
        end
        for (int k = 0; k < NUM_PORTS; k++) begin
            scan = {1'b0, rr_ptr} + (PORT_IDX_WIDTH+1)'(k);
            if (scan >= NP) begin
                scan = scan - NP;
            end
            if (!win_found && req[scan[PORT_IDX_WIDTH-1:0]] &&
                (pri_a[scan[PORT_IDX_WIDTH-1:0]] == max_pri)) begin
                win_found = 1'b1;
                win_idx   = scan[PORT_IDX_WIDTH-1:0];
            end
        end
    end

    assign beat_ext = {1'b0, beat_cnt} + {{LEN_WIDTH{1'b0}}, 1'b1};

    always_comb begin
        state_nxt   = state;
        start       = 1'b0;
        transfering = 1'b0;
        eop_g       = 1'b0;
        last_len    = 1'b0;
        pkt_end     = 1'b0;
        unique case (state)
            IDLE: begin
                if (win_found && sram_ready) begin
                    start     = 1'b1;
                    state_nxt = XFER;
                end
            end
            XFER: begin
                transfering = sram_ready;
                eop_g       = eop[grant_idx];
                last_len    = (beat_ext == len_lat);
                pkt_end     = transfering && (eop_g || last_len);
                if (pkt_end) begin
                    state_nxt = GAP;
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant     <= '0;
            grant_idx <= '0;
            beat_cnt  <= '0;
            pkt_done  <= 1'b0;
            len_err   <= 1'b0;
            rr_ptr    <= '0;
            len_lat   <= '0;
        end else begin
            pkt_done <= pkt_end;
            // Mismatch: eop before the length ran out, or length ran out
            // without eop.
            len_err  <= pkt_end && (eop_g != last_len);
            if (start) begin
                grant     <= {{(NUM_PORTS-1){1'b0}}, 1'b1} << win_idx;
                grant_idx <= win_idx;
                beat_cnt  <= '0;
                len_lat   <= (len_a[win_idx] == '0) ? FULL_LEN
                                                    : {1'b0, len_a[win_idx]};
            end else if (transfering) begin
                beat_cnt <= beat_cnt + LEN_WIDTH'(1);
                if (pkt_end) begin
                    grant  <= '0;
                    rr_ptr <= (grant_idx == LAST) ? '0
                            : grant_idx + PORT_IDX_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_wr_arbiter.sv
// tb_sram_wr_arbiter: scoreboard bench for sram_wr_arbiter.
// A transaction-level model predicts grant order and packet outcome.
module tb_sram_wr_arbiter;
    localparam int N  = 16;
    localparam int IW = 4;
    localparam int PW = 3;
    localparam int LW = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N*PW-1:0] pri_in;
    logic [N*LW-1:0] len_in;
    logic [N-1:0]  eop;
    logic          sram_ready;
    logic [N-1:0]  grant;
    logic [IW-1:0] grant_idx;
    logic          transfering;
    logic [LW-1:0] beat_cnt;
    logic          pkt_done;
    logic          len_err;

    always #5 clk = ~clk;

    sram_wr_arbiter #(
        .NUM_PORTS(N), .PORT_IDX_WIDTH(IW),
        .PRI_WIDTH(PW), .LEN_WIDTH(LW)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .pri_in(pri_in),
        .len_in(len_in), .eop(eop), .sram_ready(sram_ready),
        .grant(grant), .grant_idx(grant_idx),
        .transfering(transfering), .beat_cnt(beat_cnt),
        .pkt_done(pkt_done), .len_err(len_err)
    );

    typedef struct {
        int port;
        int words;
        int err;
        int dur;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int errors = 0;
    int checks = 0;

    int p_pri[N], p_len[N], p_eop[N], p_reps[N], reps_left[N];
    int rr_m = 0;
    bit force_rdy = 1'b1;
    int stall_at = -1;
    int stall_left = 0;
    int tb_words = 0;
    logic [N-1:0] gprev = '0;
    bit in_pkt = 1'b0;
    int cur_port, obs_words, obs_dur;
    int since = 100;
    bit gap_exact = 1'b0;

    task automatic chk(input string name, input longint act,
                       input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Reference: repeatedly serve the highest priority pending port,
    // ties taken in circular order starting at the round-robin pointer.
    task automatic model_batch(input int extra);
        int cnt[N];
        int maxp, pick, idx, l;
        exp_t x;
        for (int i = 0; i < N; i++) cnt[i] = p_reps[i];
        while (1) begin
            maxp = -1;
            for (int i = 0; i < N; i++)
                if (cnt[i] > 0 && p_pri[i] > maxp) maxp = p_pri[i];
            if (maxp < 0) break;
            pick = -1;
            for (int k = 0; k < N; k++) begin
                idx = (rr_m + k) % N;
                if (pick < 0 && cnt[idx] > 0 && p_pri[idx] == maxp)
                    pick = idx;
            end
            cnt[pick]--;
            l = (p_len[pick] == 0) ? 128 : p_len[pick];
            x.port = pick;
            if (p_eop[pick] >= 1 && p_eop[pick] <= l) begin
                x.words = p_eop[pick];
                x.err = (p_eop[pick] != l) ? 1 : 0;
            end else begin
                x.words = l;
                x.err = 1;
            end
            x.dur = (extra >= 0) ? x.words + extra : -1;
            exp_q.push_back(x);
            rr_m = (pick + 1) % N;
        end
    endtask

    task automatic clear_plan();
        for (int i = 0; i < N; i++) begin
            p_reps[i] = 0;
            p_eop[i] = 0;
            p_pri[i] = 0;
            p_len[i] = 1;
        end
    endtask

    task automatic set_port(input int i, input int pri, input int len,
                            input int eopp, input int reps);
        p_pri[i] = pri;
        p_len[i] = len;
        p_eop[i] = eopp;
        p_reps[i] = reps;
    endtask

    task automatic launch(input int extra, input bit use_model);
        if (use_model) model_batch(extra);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (p_reps[i] > 0) begin
                reps_left[i] = p_reps[i];
                pri_in[i*PW +: PW] = PW'(p_pri[i]);
                len_in[i*LW +: LW] = LW'(p_len[i]);
                req[i] = 1'b1;
            end
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || grant != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0",
                     exp_q.size());
            exp_q.delete();
            req = '0;
        end
        repeat (3) @(negedge clk);
    endtask

    // Input driver: drops req once a port's last repetition is granted,
    // then scrambles its pri/len; drives eop on the planned word and noise
    // on other ports.
    always begin
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (grant[i] && !gprev[i] && reps_left[i] > 0) begin
                reps_left[i]--;
                if (reps_left[i] == 0) begin
                    req[i] = 1'b0;
                    pri_in[i*PW +: PW] = PW'($urandom);
                    len_in[i*LW +: LW] = LW'($urandom);
                end
            end
        end
        gprev = grant;
        if (grant != 0 && tb_words == stall_at && stall_left > 0) begin
            sram_ready = 1'b0;
            stall_left--;
        end else if (force_rdy) begin
            sram_ready = 1'b1;
        end else begin
            sram_ready = ($urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < N; i++) begin
            if (grant[i])
                eop[i] = (p_eop[i] != 0) && (tb_words + 1 == p_eop[i]);
            else
                eop[i] = ($urandom_range(0, 3) == 0);
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            in_pkt = 1'b0;
            tb_words = 0;
            since = 100;
        end else begin
            if (since < 100) since++;
            chk("grant_onehot0", $onehot0(grant), 1);
            chk("len_err_alone", len_err && !pkt_done, 0);
            if (grant == 0) begin
                chk("xfer_without_grant", transfering, 0);
            end else begin
                chk("grant_vs_idx", grant == (N'(1) << grant_idx), 1);
                chk("xfer_vs_ready", transfering, sram_ready);
                chk("beat_cnt", beat_cnt, tb_words);
                if (!in_pkt) begin
                    in_pkt = 1'b1;
                    cur_port = grant_idx;
                    obs_words = 0;
                    obs_dur = 0;
                    if (gap_exact) chk("grant_gap", since, 2);
                    else chk("grant_gap_min", since >= 2, 1);
                    gap_exact = 1'b0;
                end else begin
                    chk("grant_held", grant_idx, cur_port);
                end
                obs_dur++;
                if (transfering) obs_words++;
            end
            if (in_pkt && grant == 0) begin
                in_pkt = 1'b0;
                chk("pkt_done_at_release", pkt_done, 1);
            end
            if (pkt_done) begin
                since = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pkt_done_unexpected: got 1 expected 0");
                end else begin
                    e = exp_q.pop_front();
                    chk("pkt_port", cur_port, e.port);
                    chk("pkt_words", obs_words, e.words);
                    chk("pkt_len_err", len_err, e.err);
                    if (e.dur >= 0) chk("pkt_duration", obs_dur, e.dur);
                    gap_exact = force_rdy && (exp_q.size() > 0);
                end
            end
            if (grant == 0) tb_words = 0;
            else if (transfering) tb_words++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int t, n, i, len, l, r, eopp;
        rst = 1'b1;
        req = '0;
        eop = '0;
        pri_in = '0;
        len_in = '0;
        sram_ready = 1'b0;
        for (int k = 0; k < N; k++) reps_left[k] = 0;
        clear_plan();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_grant_idx", grant_idx, 0);
        chk("rst_transfering", transfering, 0);
        chk("rst_beat_cnt", beat_cnt, 0);
        chk("rst_pkt_done", pkt_done, 0);
        chk("rst_len_err", len_err, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);

        // single port 5, latency and word count
        force_rdy = 1'b1;
        clear_plan();
        set_port(5, 2, 4, 4, 1);
        launch(0, 1'b1);
        @(negedge clk);
        chk("grant_before", grant, 0);
        @(negedge clk);
        chk("grant_port5", grant, 16'h0020);
        drain();

        // rr pointer now after port 5: port 6 beats port 5
        clear_plan();
        set_port(5, 1, 1, 1, 1);
        set_port(6, 1, 1, 1, 1);
        launch(0, 1'b1);
        drain();

        // priority then exact 3-cycle reissue
        clear_plan();
        set_port(1, 1, 3, 3, 1);
        set_port(9, 4, 3, 3, 1);
        launch(0, 1'b1);
        drain();

        // reset in the middle of port 11's packet
        clear_plan();
        set_port(11, 5, 10, 0, 1);
        launch(0, 1'b0);
        t = 0;
        while (!grant[11] && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("rst_test_grant11", grant[11], 1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_grant", grant, 0);
        chk("midrst_transfering", transfering, 0);
        chk("midrst_beat_cnt", beat_cnt, 0);
        chk("midrst_pkt_done", pkt_done, 0);
        @(negedge clk);
        chk("midrst_no_pkt_done", pkt_done, 0);
        rr_m = 0;
        exp_q.delete();
        clear_plan();
        set_port(0, 2, 2, 2, 1);
        set_port(11, 2, 2, 2, 1);
        launch(0, 1'b1);
        drain();

        // equal priorities, port 0 held for two packets
        clear_plan();
        set_port(0, 3, 1, 1, 2);
        set_port(3, 3, 1, 1, 1);
        set_port(7, 3, 1, 1, 1);
        launch(0, 1'b1);
        drain();

        // three stall cycles after word 2
        clear_plan();
        set_port(2, 0, 6, 6, 1);
        stall_at = 2;
        stall_left = 3;
        launch(3, 1'b1);
        drain();
        stall_at = -1;
        stall_left = 0;

        // early eop, then missing eop
        clear_plan();
        set_port(4, 1, 8, 3, 1);
        launch(0, 1'b1);
        drain();
        clear_plan();
        set_port(4, 1, 2, 0, 1);
        launch(0, 1'b1);
        drain();

        // length field 0 = 128 words
        clear_plan();
        set_port(13, 6, 0, 128, 1);
        launch(0, 1'b1);
        drain();

        // randomized batches
        force_rdy = 1'b0;
        for (int b = 0; b < 30; b++) begin
            clear_plan();
            n = $urandom_range(1, 5);
            for (int j = 0; j < n; j++) begin
                i = $urandom_range(0, N - 1);
                len = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 10);
                l = (len == 0) ? 128 : len;
                r = $urandom_range(0, 3);
                if (r == 0) eopp = 0;
                else if (r == 1) eopp = $urandom_range(1, l + 1);
                else eopp = l;
                set_port(i, $urandom_range(0, 7), len, eopp,
                         $urandom_range(1, 2));
            end
            launch(-1, 1'b1);
            drain();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_wr_arbiter.md
# sram_wr_arbiter

Packet-level write arbiter for the shared SRAM write path. Selects one of NUM_PORTS ingress ports with a queued packet (highest priority first, round-robin among equal priorities), holds the grant for the whole packet, and drives `transfering` to the data/address staging stage. Packet end is taken from the granted port's `eop` or from its declared length, whichever comes first; a mismatch is flagged. Stalls when the SRAM write path is not ready.

## Interface
- NUM_PORTS, 16, number of ingress ports
- PORT_IDX_WIDTH, 4, width of port index (log2 NUM_PORTS)
- PRI_WIDTH, 3, per-port priority width; larger value = higher priority
- LEN_WIDTH, 7, per-port packet length width (words)

- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high
- req  in  NUM_PORTS  port i has a packet queued; level, held until granted
- pri_in  in  NUM_PORTS*PRI_WIDTH  priority of port i at bits [i*PRI_WIDTH +: PRI_WIDTH]
- len_in  in  NUM_PORTS*LEN_WIDTH  packet length of port i, same packing; 0 means 2^LEN_WIDTH
- eop  in  NUM_PORTS  end-of-packet strobe per port, marks the last word
- sram_ready  in  1  write path can accept a word this cycle (inverse of busy)
- grant  out  NUM_PORTS  one-hot grant, held for the packet
- grant_idx  out  PORT_IDX_WIDTH  binary index of granted port
- transfering  out  1  a word of the granted packet is transferred this cycle
- beat_cnt  out  LEN_WIDTH  words already transferred in current packet
- pkt_done  out  1  one-cycle pulse after packet end
- len_err  out  1  one-cycle pulse with pkt_done when eop and length disagree

## Operation
- States: IDLE, XFER, GAP.
- IDLE: if |req and sram_ready, pick winner; register grant, grant_idx, latched length L; beat_cnt<=0; go XFER. Else stay.
- Winner: max pri_in over requesting ports; ties broken by scanning from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, …, NUM_PORTS-1, 0, …).
- XFER: transfering = sram_ready (combinational, only in XFER). Each transfering cycle increments beat_cnt. sram_ready low: stall, beat_cnt holds, grant holds.
- End condition on a transfering cycle: eop[grant_idx]=1 OR beat_cnt+1 == L. On end: go GAP, clear grant, rr_ptr <= grant_idx+1 (wrap), pkt_done=1 next cycle.
- len_err=1 with pkt_done if eop[grant_idx] asserted with beat_cnt+1 != L, or length reached without eop[grant_idx].
- eop from non-granted ports and eop while not transfering: ignored.
- req of the granted port is not sampled during XFER; changes to pri_in/len_in after grant have no effect on the packet.
- GAP: one idle cycle, grant zero; go IDLE.
- Reset values: state IDLE, grant 0, grant_idx 0, transfering 0, beat_cnt 0, pkt_done 0, len_err 0, rr_ptr 0.
- rst mid-packet: all above values next cycle; the aborted packet produces no pkt_done.

## Timing
- req visible in IDLE at cycle N (sram_ready=1) -> grant and first possible transfering at N+1.
- Last word at cycle M -> grant low and pkt_done (and len_err) at M+1 (GAP), IDLE at M+2, next grant earliest M+3.
- Packet of L words with no stalls: transfering high exactly L consecutive cycles.
- Each stall cycle adds exactly one cycle to packet duration.
- grant is always one-hot or zero; transfering implies grant nonzero.

## Test plan
- Single port 5 req, pri 2, len 4, eop on 4th word, sram_ready=1 -> grant=0x0020 at N+1, transfering 4 cycles, pkt_done at M+1, len_err=0, rr_ptr=6.
- Ports 1 and 9 req, pri 1 and 4 -> port 9 granted first; port 1 granted 3 cycles after port 9's last word.
- Ports 0,3,7 req, all pri 3, len 1 each, held -> grant order 0,3,7,0 (round-robin).
- Port 2 len 6, sram_ready low for 3 cycles after word 2 -> beat_cnt holds 2, transfering low 3 cycles, total 9 cycles with grant, pkt_done once.
- Port 4 len 8, eop after word 3 -> packet ends after 3 words, pkt_done=1 and len_err=1; len 2 with no eop -> ends after 2 words, len_err=1.
- rst asserted mid-XFER of port 11 -> next cycle grant=0, transfering=0, beat_cnt=0, no pkt_done; with ports 0 and 11 equal priority, port 0 wins next.
